// File: rtl/regfile_pkg.sv
// Shared widths, types and constants for the 2-read/1-write register file.
package regfile_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_2r1w_sb_scoreboard.sv
// Pending-write scoreboard: reserve at issue, release at writeback, stall decode on busy sources.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREGS  = regfile_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              stall,
  output logic [NREGS-1:0]  pending
);
  logic [NREGS-1:0] pending_q, pending_d;
  logic             wr_live, iss_live;

  assign wr_live  = wr_en && (wr_addr != '0);
  assign iss_live = iss_valid && (iss_addr != '0);

  // A retiring writeback forwards its data, so it does not hold up the reader.
  function automatic logic src_busy(input logic [ADDR_W-1:0] x);
    return pending_q[x] && !(wr_live && (wr_addr == x));
  endfunction

  always_comb begin
    pending_d = pending_q;
    if (wr_live)  pending_d[wr_addr]  = 1'b0;
    // Set after clear: a new producer replaces the one retiring this edge.
    if (iss_live) pending_d[iss_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign stall   = !reset && rd_en && (src_busy(rd_addr_a) || src_busy(rd_addr_b));
  assign pending = pending_q;
endmodule

// File: rtl/regfile_2r1w_sb.sv
// Register file with write-first bypassed registered reads and a pending-write scoreboard.
module regfile_2r1w_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREGS  = regfile_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  output logic              stall,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [NREGS-1:0]  pending
);
  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0]            rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0]            rd_data_b_q, rd_data_b_d;
  logic                         rd_valid_q, rd_valid_d;
  logic                         wr_live, rd_accept;

  rf_scoreboard #(.ADDR_W(ADDR_W), .NREGS(NREGS)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .stall     (stall),
    .pending   (pending)
  );

  assign wr_live   = wr_en && (wr_addr != ZERO_REG);
  assign rd_accept = rd_en && !stall;

  function automatic logic [DATA_W-1:0] rd_value(input logic [ADDR_W-1:0] x);
    if (x == ZERO_REG)              return '0;
    if (wr_live && (wr_addr == x))  return wr_data;
    return regs_q[x];
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (wr_live) regs_d[wr_addr] = wr_data;
    regs_d[0] = '0;
  end

  always_comb begin
    rd_valid_d  = rd_accept;
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (rd_accept) begin
      rd_data_a_d = rd_value(rd_addr_a);
      rd_data_b_d = rd_value(rd_addr_b);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q      <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_valid  = rd_valid_q;
endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
- Register file that consumes the write-register address produced by the write-register select mux (RegDst path).
- Writeback side: one synchronous write port, fed by the selected 5-bit address.
- Decode side: two registered read ports with write-first bypass.
- Pending-write scoreboard: reserves a destination at issue and releases it at writeback; stalls decode while a source operand is still pending.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NREGS, 32, register count (2**ADDR_W); register 0 is hardwired zero

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- rd_en  in  1  decode requests an operand read this cycle
- rd_addr_a  in  ADDR_W  source register A
- rd_addr_b  in  ADDR_W  source register B
- rd_data_a  out  DATA_W  registered operand A
- rd_data_b  out  DATA_W  registered operand B
- rd_valid  out  1  rd_data_a/b are valid for the read accepted last cycle
- stall  out  1  combinational; read refused because a source is pending
- iss_valid  in  1  instruction issued with a destination register
- iss_addr  in  ADDR_W  destination being reserved (write-register select output at issue)
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination (write-register select output at writeback)
- wr_data  in  DATA_W  writeback data
- pending  out  NREGS  scoreboard bit vector, for debug and verification

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on port reset.
- Reset values, all applied at the clk edge while reset=1:
  - all registers = 0
  - pending = 0
  - rd_data_a = rd_data_b = 0
  - rd_valid = 0
  - stall reads 0 while reset=1
  - inputs are ignored while reset=1
- Register 0:
  - writes to address 0 are discarded
  - reads of address 0 return 0
  - pending[0] is never set
- Write:
  - when wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data at the edge
  - pending[wr_addr] is cleared at the same edge
- Issue:
  - when iss_valid=1 and iss_addr!=0, pending[iss_addr] <= 1 at the edge
- Same edge, iss_addr == wr_addr (nonzero): set wins, so pending stays 1 (a new producer replaces the retiring one). The data write still occurs.
- Source-pending test: src_busy(x) = pending[x] && !(wr_en && wr_addr==x && x!=0).
- Stall: stall = rd_en && (src_busy(rd_addr_a) || src_busy(rd_addr_b)). The same-cycle writeback is bypassed, so it does not stall.
- Read accept: rd_en && !stall. Latency is 1 cycle.
  - At the edge, rd_data_x <= (wr_en && wr_addr==rd_addr_x && rd_addr_x!=0) ? wr_data : regs[rd_addr_x] (write-first bypass).
  - rd_valid <= 1 at that edge.
- Read not accepted (rd_en=0 or stall=1): rd_valid <= 0 and rd_data_a/b hold their previous values.
- Reading the same register on both ports is legal; both outputs get identical data.
- Issue does not affect the stall decision in the same cycle; the new pending bit is visible from the next cycle.
- A write to a non-pending register is legal: the data updates and pending is unchanged (already 0).
- Reset mid-operation: pending is cleared, an in-flight read is dropped (rd_valid=0 next cycle), and a concurrent wr_en is ignored.
- No FSM. Sequential state: the register array, the pending vector, and the read output registers.

Decomposition:
- Shared package regfile_pkg holds:
  - the ADDR_W/DATA_W/NREGS constants
  - typedef reg_addr_t (logic [ADDR_W-1:0])
  - typedef reg_data_t (logic [DATA_W-1:0])
  - constant ZERO_REG = 0
- One sub-module, rf_scoreboard:
  - contains the pending vector, its set/clear priority logic, and the src_busy/stall computation
  - the top level holds the array, the bypass and the read registers

Test Plan:
- Reset then read: reset 2 cycles, rd_en=1, rd_addr_a=5, rd_addr_b=0 -> next cycle rd_valid=1, rd_data_a=0, rd_data_b=0, stall=0, pending=0.
- Write then read with bypass: wr_en=1, wr_addr=7, wr_data=32'hDEADBEEF, with rd_en=1, rd_addr_a=7 in the same cycle -> stall=0; next cycle rd_data_a=32'hDEADBEEF. A later read of 7 returns the same value.
- Scoreboard stall:
  - cycle 0: iss_valid=1, iss_addr=9 -> pending[9]=1 after the edge.
  - cycle 1: rd_en=1, rd_addr_b=9 -> stall=1; next cycle rd_valid=0.
  - cycle 3: wr_en=1, wr_addr=9, wr_data=32'h12345678 with the read held -> stall=0; next cycle rd_data_b=32'h12345678 and pending[9]=0.
- Register 0 guard: iss_valid=1, iss_addr=0, then wr_en=1, wr_addr=0, wr_data=32'hFFFFFFFF, then read 0 -> pending[0]=0, stall=0, rd_data=0.
- Issue/write collision: pending[4]=1; same edge iss_valid=1, iss_addr=4 and wr_en=1, wr_addr=4, wr_data=32'hA5 -> pending[4] stays 1 and regs[4]=32'hA5 (checked after a second write clears pending).
- Reset mid-stream: pending[3]=pending[12]=1 and rd_valid=1; assert reset together with wr_en=1, wr_addr=3 -> after the edge pending=0, rd_valid=0, and a later read of 3 returns 0.
